// File: rtl/rob_rename_pkg.sv
// Shared rename/ROB definitions: pool geometry, null tag and the port structs
// reused by dispatch, the ROB and the rename buffer pool.
package rob_rename_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_TAGS = 32;
    localparam int TAG_W    = $clog2(NUM_TAGS);
    localparam int ALLOC_W  = 2;
    localparam int WB_W     = 2;
    localparam int RD_W     = 4;
    localparam int FREE_W   = 2;

    localparam logic [TAG_W-1:0] NULL_TAG = '0;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic avail;
        tag_t tag;
    } alloc_port_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        data_t data;
    } wb_port_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } free_port_t;

    // Population count of a tag bitmap, sized for free_count arithmetic.
    function automatic logic [TAG_W:0] count_ones(input logic [NUM_TAGS-1:0] v);
        logic [TAG_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            n = n + (TAG_W+1)'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/rename_buffer_pool_if.sv
// Dispatch / writeback / read / ROB-side bundle of the rename buffer pool.
interface rename_buffer_pool_if import rob_rename_pkg::*; ();

    logic [ALLOC_W-1:0]             alloc_avail;
    logic [ALLOC_W-1:0][TAG_W-1:0]  alloc_tag;
    logic [ALLOC_W-1:0]             alloc_req;
    logic [WB_W-1:0]                wb_valid;
    logic [WB_W-1:0][TAG_W-1:0]     wb_tag;
    logic [WB_W-1:0][DATA_W-1:0]    wb_data;
    logic [RD_W-1:0][TAG_W-1:0]     rd_tag;
    logic [RD_W-1:0][DATA_W-1:0]    rd_data;
    logic [RD_W-1:0]                rd_ready;
    logic [FREE_W-1:0]              free_valid;
    logic [FREE_W-1:0][TAG_W-1:0]   free_tag;
    logic                           flush;
    logic [TAG_W:0]                 free_count;
    logic [1:0]                     err_sticky;

    modport slave (
        output alloc_avail, alloc_tag, rd_data, rd_ready, free_count, err_sticky,
        input  alloc_req, wb_valid, wb_tag, wb_data, rd_tag, free_valid, free_tag, flush
    );

    modport master (
        input  alloc_avail, alloc_tag, rd_data, rd_ready, free_count, err_sticky,
        output alloc_req, wb_valid, wb_tag, wb_data, rd_tag, free_valid, free_tag, flush
    );

endinterface

// File: rtl/free_tag_picker.sv
// Finds the ALLOC_W lowest free tags (tag 0 excluded) from the busy bitmap.
// Port k receives the k-th lowest free tag, both encoded and one-hot.
module free_tag_picker import rob_rename_pkg::*; (
    input  logic [NUM_TAGS-1:1]                busy,
    output logic [ALLOC_W-1:0]                 avail,
    output logic [ALLOC_W-1:0][TAG_W-1:0]      tag,
    output logic [ALLOC_W-1:0][NUM_TAGS-1:0]   onehot
);

    int found;

    // Scan upward; each free tag goes to the port whose index equals the number of free tags seen so far.
    always_comb begin
        avail  = '0;
        tag    = '0;
        onehot = '0;
        found  = 0;
        for (int t = 1; t < NUM_TAGS; t++) begin
            if (!busy[t]) begin
                for (int k = 0; k < ALLOC_W; k++) begin
                    if (found == k) begin
                        avail[k]     = 1'b1;
                        tag[k]       = TAG_W'(t);
                        onehot[k][t] = 1'b1;
                    end
                end
                found = found + 1;
            end
        end
    end

endmodule

// File: rtl/rename_buffer_pool.sv
// Rename buffer pool: speculative result storage with an integrated tag
// allocator, per-tag ready bits and bypassed operand read ports.
module rename_buffer_pool import rob_rename_pkg::*; (
    input  logic                 clk,
    input  logic                 rst_n,
    rename_buffer_pool_if.slave  bus
);

    logic [NUM_TAGS-1:0] busy, ready;
    data_t               data_q [NUM_TAGS];
    logic [TAG_W:0]      cnt_q;
    logic [1:0]          err_q;

    logic [ALLOC_W-1:0]               pick_avail;
    logic [ALLOC_W-1:0][TAG_W-1:0]    pick_tag;
    logic [ALLOC_W-1:0][NUM_TAGS-1:0] pick_oh;

    wb_port_t   wb_p [WB_W];
    free_port_t fr_p [FREE_W];

    logic [NUM_TAGS-1:0] grant_mask, wb_mask, free_mask;
    logic [WB_W-1:0]     wb_hit, wb_keep;
    logic [TAG_W:0]      n_grant;
    logic                err_wb, err_free;
    logic [RD_W-1:0][DATA_W-1:0] rd_data_c;
    logic [RD_W-1:0]             rd_ready_c;

    free_tag_picker u_picker (
        .busy   (busy[NUM_TAGS-1:1]),
        .avail  (pick_avail),
        .tag    (pick_tag),
        .onehot (pick_oh)
    );

    for (genvar p = 0; p < WB_W; p++) begin : g_wb
        assign wb_p[p] = '{valid: bus.wb_valid[p], tag: bus.wb_tag[p], data: bus.wb_data[p]};
    end
    for (genvar f = 0; f < FREE_W; f++) begin : g_fr
        assign fr_p[f] = '{valid: bus.free_valid[f], tag: bus.free_tag[f]};
    end

    assign bus.alloc_avail = pick_avail;
    assign bus.alloc_tag   = pick_tag;
    assign bus.free_count  = cnt_q;
    assign bus.err_sticky  = err_q;
    assign bus.rd_data     = rd_data_c;
    assign bus.rd_ready    = rd_ready_c;

    // Qualify grants, writebacks and frees against the registered busy bitmap.
    always_comb begin
        grant_mask = '0;
        n_grant    = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            if (bus.alloc_req[k] && pick_avail[k]) begin
                grant_mask = grant_mask | pick_oh[k];
                n_grant    = n_grant + (TAG_W+1)'(1);
            end
        end
        free_mask = '0;
        err_free  = 1'b0;
        for (int f = 0; f < FREE_W; f++) begin
            if (fr_p[f].valid && fr_p[f].tag != NULL_TAG) begin
                if (busy[fr_p[f].tag]) free_mask[fr_p[f].tag] = 1'b1;
                else                   err_free = 1'b1;
            end
        end
        wb_hit  = '0;
        wb_keep = '0;
        wb_mask = '0;
        err_wb  = 1'b0;
        for (int p = 0; p < WB_W; p++) begin
            if (wb_p[p].valid && wb_p[p].tag != NULL_TAG) begin
                if (busy[wb_p[p].tag]) begin
                    wb_hit[p]  = 1'b1;
                    // A free on the same tag wins; the result is dropped.
                    wb_keep[p] = !free_mask[wb_p[p].tag];
                    wb_mask[wb_p[p].tag] = 1'b1;
                end else begin
                    err_wb = 1'b1;
                end
            end
        end
    end

    // Operand reads: tag 0 is a constant, then the highest matching writeback, then storage.
    always_comb begin
        rd_data_c  = '0;
        rd_ready_c = '0;
        for (int r = 0; r < RD_W; r++) begin
            rd_data_c[r]  = data_q[bus.rd_tag[r]];
            rd_ready_c[r] = ready[bus.rd_tag[r]];
            if (bus.rd_tag[r] == NULL_TAG) begin
                rd_data_c[r]  = '0;
                rd_ready_c[r] = 1'b1;
            end else begin
                for (int p = 0; p < WB_W; p++) begin
                    if (wb_hit[p] && wb_p[p].tag == bus.rd_tag[r]) begin
                        rd_data_c[r]  = wb_p[p].data;
                        rd_ready_c[r] = 1'b1;
                    end
                end
            end
        end
    end

    // Busy/ready bitmaps, free counter and sticky errors; flush squashes the cycle's traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            ready <= '0;
            cnt_q <= (TAG_W+1)'(NUM_TAGS-1);
            err_q <= '0;
        end else if (bus.flush) begin
            busy  <= '0;
            ready <= '0;
            cnt_q <= (TAG_W+1)'(NUM_TAGS-1);
        end else begin
            busy  <= (busy & ~free_mask) | grant_mask;
            ready <= (ready | wb_mask) & ~free_mask & ~grant_mask;
            cnt_q <= cnt_q - n_grant + count_ones(free_mask);
            err_q <= err_q | {err_wb, err_free};
        end
    end

    // Result storage; later ports overwrite earlier ones so the highest port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAGS; i++)
                data_q[i] <= '0;
        end else if (!bus.flush) begin
            for (int p = 0; p < WB_W; p++)
                if (wb_keep[p])
                    data_q[wb_p[p].tag] <= wb_p[p].data;
        end
    end

endmodule

// File: tb/tb_rename_buffer_pool.sv
// Directed plus randomized checks of rename_buffer_pool against a tag-level
// reference model (busy/ready/data per tag, free list derived by scanning).
module tb_rename_buffer_pool;
    import rob_rename_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    rename_buffer_pool_if bus();

    rename_buffer_pool dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    bit          m_busy  [NUM_TAGS];
    bit          m_ready [NUM_TAGS];
    logic [15:0] m_data  [NUM_TAGS];
    bit   [1:0]  m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int t = 0; t < NUM_TAGS; t++) begin
            m_busy[t] = 0; m_ready[t] = 0; m_data[t] = '0;
        end
        m_err = '0;
    endfunction

    function automatic int offer(input int k);
        int c = 0;
        for (int t = 1; t < NUM_TAGS; t++)
            if (!m_busy[t]) begin
                if (c == k) return t;
                c++;
            end
        return 0;
    endfunction

    function automatic int model_fc();
        int n = NUM_TAGS - 1;
        for (int t = 1; t < NUM_TAGS; t++) if (m_busy[t]) n--;
        return n;
    endfunction

    function automatic int rand_busy();
        int q[$];
        for (int t = 1; t < NUM_TAGS; t++) if (m_busy[t]) q.push_back(t);
        if (q.size() == 0) return int'($urandom_range(NUM_TAGS-1, 1));
        return q[$urandom_range(q.size()-1, 0)];
    endfunction

    // Apply one clock of traffic to the model, from the pre-edge state.
    function automatic void model_step();
        bit b0 [NUM_TAGS];
        bit fr [NUM_TAGS];
        int g  [ALLOC_W];
        if (bus.flush) begin
            for (int t = 0; t < NUM_TAGS; t++) begin m_busy[t] = 0; m_ready[t] = 0; end
            return;
        end
        b0 = m_busy;
        for (int t = 0; t < NUM_TAGS; t++) fr[t] = 0;
        for (int k = 0; k < ALLOC_W; k++) g[k] = bus.alloc_req[k] ? offer(k) : 0;
        for (int f = 0; f < FREE_W; f++) begin
            int t = int'(bus.free_tag[f]);
            if (bus.free_valid[f] && t != 0) begin
                if (b0[t]) fr[t] = 1; else m_err[0] = 1;
            end
        end
        for (int p = 0; p < WB_W; p++) begin
            int t = int'(bus.wb_tag[p]);
            if (bus.wb_valid[p] && t != 0) begin
                if (!b0[t]) m_err[1] = 1;
                else if (!fr[t]) begin m_data[t] = bus.wb_data[p]; m_ready[t] = 1; end
            end
        end
        for (int t = 1; t < NUM_TAGS; t++) if (fr[t]) begin m_busy[t] = 0; m_ready[t] = 0; end
        for (int k = 0; k < ALLOC_W; k++) if (g[k] != 0) begin m_busy[g[k]] = 1; m_ready[g[k]] = 0; end
    endfunction

    task automatic clear_inputs();
        bus.alloc_req  = '0;
        bus.wb_valid   = '0;
        bus.wb_tag     = '0;
        bus.wb_data    = '0;
        bus.free_valid = '0;
        bus.free_tag   = '0;
        bus.flush      = 1'b0;
        for (int r = 0; r < RD_W; r++) bus.rd_tag[r] = TAG_W'($urandom_range(NUM_TAGS-1, 0));
    endtask

    // Compare every output with the model for the inputs currently applied.
    task automatic check_now();
        #1;
        for (int k = 0; k < ALLOC_W; k++) begin
            int o = offer(k);
            chk($sformatf("alloc_avail%0d", k), 64'(bus.alloc_avail[k]), 64'(o != 0));
            chk($sformatf("alloc_tag%0d", k), 64'(bus.alloc_tag[k]), 64'(o));
        end
        chk("free_count", 64'(bus.free_count), 64'(model_fc()));
        chk("err_sticky", 64'(bus.err_sticky), 64'(m_err));
        for (int r = 0; r < RD_W; r++) begin
            int t = int'(bus.rd_tag[r]);
            bit er = 0;
            logic [15:0] ed = '0;
            if (t == 0) er = 1;
            else begin
                er = m_ready[t]; ed = m_data[t];
                for (int p = 0; p < WB_W; p++)
                    if (bus.wb_valid[p] && int'(bus.wb_tag[p]) == t && m_busy[t]) begin
                        er = 1; ed = bus.wb_data[p];
                    end
            end
            chk($sformatf("rd_ready%0d", r), 64'(bus.rd_ready[r]), 64'(er));
            if (er) chk($sformatf("rd_data%0d", r), 64'(bus.rd_data[r]), 64'(ed));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic cycle();
        check_now();
        advance();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        model_reset();
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then dual grant of tags 1 and 2
        check_now();
        chk("reset_fc", 64'(bus.free_count), 64'd31);
        chk("reset_tag0", 64'(bus.alloc_tag[0]), 64'd1);
        chk("reset_tag1", 64'(bus.alloc_tag[1]), 64'd2);
        bus.alloc_req = 2'b11;
        advance();
        check_now();
        chk("offer_3", 64'(bus.alloc_tag[0]), 64'd3);
        chk("offer_4", 64'(bus.alloc_tag[1]), 64'd4);
        chk("fc_29", 64'(bus.free_count), 64'd29);

        // Single grant plus writeback of tag 1 read through the bypass
        bus.alloc_req = 2'b01;
        bus.wb_valid = 2'b01; bus.wb_tag[0] = 5'd1; bus.wb_data[0] = 16'hBEEF;
        bus.rd_tag[0] = 5'd1;
        check_now();
        chk("bypass_data", 64'(bus.rd_data[0]), 64'hBEEF);
        chk("bypass_ready", 64'(bus.rd_ready[0]), 64'd1);
        advance();
        bus.rd_tag[0] = 5'd1;
        check_now();
        chk("stored_data", 64'(bus.rd_data[0]), 64'hBEEF);
        chk("stored_ready", 64'(bus.rd_ready[0]), 64'd1);
        advance();

        // Port 1 alone takes the second offered tag
        bus.alloc_req = 2'b10;
        cycle();

        // Exhaust the pool
        for (int i = 0; i < 20 && offer(0) != 0; i++) begin
            bus.alloc_req = 2'b11;
            cycle();
        end
        check_now();
        chk("full_avail", 64'(bus.alloc_avail), 64'd0);
        chk("full_fc", 64'(bus.free_count), 64'd0);
        bus.free_valid = 2'b11; bus.free_tag[0] = 5'd5; bus.free_tag[1] = 5'd9;
        advance();
        check_now();
        chk("refree_5", 64'(bus.alloc_tag[0]), 64'd5);
        chk("refree_9", 64'(bus.alloc_tag[1]), 64'd9);
        chk("refree_fc", 64'(bus.free_count), 64'd2);
        advance();

        // Double free and writeback to a free tag
        bus.free_valid = 2'b01; bus.free_tag[0] = 5'd7;
        cycle();
        bus.free_valid = 2'b10; bus.free_tag[1] = 5'd7;
        cycle();
        check_now();
        chk("dbl_free_err", 64'(bus.err_sticky), 64'b01);
        bus.free_valid = 2'b01; bus.free_tag[0] = 5'd12;
        advance();
        bus.wb_valid = 2'b10; bus.wb_tag[1] = 5'd12; bus.wb_data[1] = 16'h1234;
        cycle();
        bus.rd_tag[0] = 5'd12;
        check_now();
        chk("wb_free_err", 64'(bus.err_sticky), 64'b11);
        chk("wb_free_rdy", 64'(bus.rd_ready[0]), 64'd0);
        advance();

        // Flush with concurrent grants and writeback
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.alloc_req = 2'b11;
            cycle();
        end
        bus.flush = 1'b1; bus.alloc_req = 2'b11;
        bus.wb_valid = 2'b01; bus.wb_tag[0] = 5'd3; bus.wb_data[0] = 16'hAAAA;
        cycle();
        bus.rd_tag[0] = 5'd3;
        check_now();
        chk("flush_fc", 64'(bus.free_count), 64'd31);
        chk("flush_tag0", 64'(bus.alloc_tag[0]), 64'd1);
        chk("flush_tag1", 64'(bus.alloc_tag[1]), 64'd2);
        chk("flush_rdy3", 64'(bus.rd_ready[0]), 64'd0);
        advance();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.alloc_req = 2'($urandom);
            if ($urandom_range(39, 0) == 0) begin
                bus.flush = 1'b1;
            end else begin
                for (int p = 0; p < WB_W; p++) begin
                    bus.wb_valid[p] = ($urandom_range(2, 0) != 0);
                    bus.wb_tag[p]   = TAG_W'(($urandom_range(15, 0) == 0) ?
                                      $urandom_range(NUM_TAGS-1, 0) : rand_busy());
                    bus.wb_data[p]  = 16'($urandom);
                end
                for (int f = 0; f < FREE_W; f++) begin
                    bus.free_valid[f] = ($urandom_range(3, 0) == 0);
                    bus.free_tag[f]   = TAG_W'(($urandom_range(15, 0) == 0) ?
                                        $urandom_range(NUM_TAGS-1, 0) : rand_busy());
                end
                if (bus.free_tag[1] == bus.free_tag[0]) bus.free_valid[1] = 1'b0;
            end
            for (int r = 0; r < RD_W; r++)
                if ($urandom_range(1, 0) == 0) bus.rd_tag[r] = TAG_W'(rand_busy());
                else if ($urandom_range(1, 0) == 0) bus.rd_tag[r] = bus.wb_tag[r % WB_W];
            cycle();
        end

        // Asynchronous reset between edges
        bus.alloc_req = 2'b11;
        bus.rd_tag[0] = TAG_W'(rand_busy());
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_fc", 64'(bus.free_count), 64'd31);
        chk("arst_err", 64'(bus.err_sticky), 64'd0);
        chk("arst_avail", 64'(bus.alloc_avail), 64'b11);
        chk("arst_tag0", 64'(bus.alloc_tag[0]), 64'd1);
        chk("arst_rdy", 64'(bus.rd_ready[0]), 64'(bus.rd_tag[0] == 0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        for (int i = 0; i < 20; i++) begin
            bus.alloc_req = 2'($urandom);
            bus.wb_valid = 2'b01; bus.wb_tag[0] = TAG_W'(rand_busy()); bus.wb_data[0] = 16'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
